// File: rtl/core_pkg.sv
// Shared definitions for the scalar core control path: state encoding,
// PC defaults and small decode helpers.
package core_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5,
      ST_IDLE   = 3'd7
   } state_t;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;

   // Cycles spent in IDLE or HALT are not charged to the performance counter.
   function automatic logic is_active(input state_t s);
      return (s != ST_IDLE) && (s != ST_HALT);
   endfunction

   function automatic logic is_word_aligned(input logic [31:0] addr);
      return addr[1:0] == 2'b00;
   endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Handshake, branch and status bundle between the sequencer and the
// surrounding core (memories, decoder, exec stage, loader).
interface core_sequencer_if;
   import core_pkg::*;

   logic        start;
   logic        imem_ready;
   logic        imem_req;
   logic        halt_insn;
   logic        exec_multi;
   logic        exec_done;
   logic        mem_read;
   logic        mem_write;
   logic        dmem_ready;
   logic        dmem_req;
   logic        dmem_we;
   logic        branch;
   logic [31:0] branch_addr;
   state_t      state;
   logic [31:0] pc;
   logic        halted;
   logic        fault;
   logic [31:0] cycle_count;
   logic [31:0] instret;

   modport master (
      input  start, imem_ready, halt_insn, exec_multi, exec_done,
             mem_read, mem_write, dmem_ready, branch, branch_addr,
      output imem_req, dmem_req, dmem_we, state, pc, halted, fault,
             cycle_count, instret
   );

   modport slave (
      output start, imem_ready, halt_insn, exec_multi, exec_done,
             mem_read, mem_write, dmem_ready, branch, branch_addr,
      input  imem_req, dmem_req, dmem_we, state, pc, halted, fault,
             cycle_count, instret
   );

endinterface

// File: rtl/core_sequencer_perf_counters.sv
// Free-running active-cycle and retired-instruction counters; both wrap
// silently at 2^32.
module perf_counters (
   input  logic        clk,
   input  logic        rst,
   input  logic        active,
   input  logic        inc,
   output logic [31:0] cycle_count,
   output logic [31:0] instret
);

   // Counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_count <= 32'd0;
         instret     <= 32'd0;
      end else begin
         if (active) begin
            cycle_count <= cycle_count + 32'd1;
         end
         if (inc) begin
            instret <= instret + 32'd1;
         end
      end
   end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control sequencer: steps FETCH..WB, owns the PC, runs the
// instruction/data memory handshakes and stops the core on halt or fault.
module core_sequencer
   import core_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   core_sequencer_if.master  bus
);

   state_t      state;
   state_t      next_state;
   logic [31:0] pc;
   logic        halted;
   logic        fault;
   logic        retire;
   logic        fault_set;
   logic        mem_access;
   logic [31:0] cycle_count;
   logic [31:0] instret;

   assign mem_access = bus.mem_read || bus.mem_write;

   // Next-state decode; retire and fault_set are single-cycle WB outcomes.
   always_comb begin
      next_state = state;
      retire     = 1'b0;
      fault_set  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.start) next_state = ST_FETCH;
            else           next_state = ST_IDLE;
         end
         ST_FETCH: begin
            if (bus.imem_ready) next_state = ST_DECODE;
            else                next_state = ST_FETCH;
         end
         ST_DECODE: begin
            if (bus.halt_insn) next_state = ST_HALT;
            else               next_state = ST_EXEC;
         end
         ST_EXEC: begin
            if (!bus.exec_multi || bus.exec_done) next_state = ST_MEM;
            else                                  next_state = ST_EXEC;
         end
         ST_MEM: begin
            if (!mem_access || bus.dmem_ready) next_state = ST_WB;
            else                               next_state = ST_MEM;
         end
         ST_WB: begin
            if (bus.branch && !is_word_aligned(bus.branch_addr)) begin
               next_state = ST_HALT;
               fault_set  = 1'b1;
            end else begin
               next_state = ST_FETCH;
               retire     = 1'b1;
            end
         end
         ST_HALT: begin
            next_state = ST_HALT;
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= next_state;
   end

   // PC and sticky status; halted tracks the HALT state as a flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc     <= RESET_PC;
         halted <= 1'b0;
         fault  <= 1'b0;
      end else begin
         if (retire) begin
            pc <= bus.branch ? bus.branch_addr : (pc + PC_STEP);
         end
         halted <= (next_state == ST_HALT);
         fault  <= fault | fault_set;
      end
   end

   perf_counters u_perf_counters (
      .clk         (clk),
      .rst         (rst),
      .active      (is_active(state)),
      .inc         (retire),
      .cycle_count (cycle_count),
      .instret     (instret)
   );

   // Strobes come straight from the state register, so they only move on edges.
   assign bus.imem_req    = (state == ST_FETCH);
   assign bus.dmem_req    = (state == ST_MEM) && mem_access;
   assign bus.dmem_we     = (state == ST_MEM) && bus.mem_write;
   assign bus.state       = state;
   assign bus.pc          = pc;
   assign bus.halted      = halted;
   assign bus.fault       = fault;
   assign bus.cycle_count = cycle_count;
   assign bus.instret     = instret;

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized bench for core_sequencer: instructions are described at the
// transaction level and expanded into the expected per-cycle stage walk.
module tb_core_sequencer;

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_HALT   = 3'd5;
   localparam logic [2:0] S_IDLE   = 3'd7;

   logic clk = 1'b0;
   logic rst;
   core_sequencer_if bus();

   core_sequencer #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic [31:0] m_pc;
   logic [31:0] m_cyc;
   logic [31:0] m_ret;
   logic        m_halted;
   logic        m_fault;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc     = 32'h0000_0000;
      m_cyc    = 32'd0;
      m_ret    = 32'd0;
      m_halted = 1'b0;
      m_fault  = 1'b0;
   endtask

   // One clock: check outputs for the expected stage, drive the stage's own
   // input to rel and randomise every input that stage must ignore.
   task automatic tick(input logic [2:0] es, input logic rel);
      logic exp_dreq;
      exp_dreq = (es == S_MEM) && (bus.mem_read || bus.mem_write);
      check_eq("state",    32'(bus.state),    32'(es));
      check_eq("imem_req", 32'(bus.imem_req), 32'(es == S_FETCH));
      check_eq("dmem_req", 32'(bus.dmem_req), 32'(exp_dreq));
      check_eq("dmem_we",  32'(bus.dmem_we),  32'(exp_dreq && bus.mem_write));
      check_eq("pc",       bus.pc,            m_pc);
      check_eq("halted",   32'(bus.halted),   32'(m_halted));
      check_eq("fault",    32'(bus.fault),    32'(m_fault));
      check_eq("cycles",   bus.cycle_count,   m_cyc);
      check_eq("instret",  bus.instret,       m_ret);
      bus.start      = 1'($urandom);
      bus.imem_ready = 1'($urandom);
      bus.halt_insn  = 1'($urandom);
      bus.exec_done  = 1'($urandom);
      bus.dmem_ready = 1'($urandom);
      case (es)
         S_IDLE:   bus.start      = rel;
         S_FETCH:  bus.imem_ready = rel;
         S_DECODE: bus.halt_insn  = rel;
         S_EXEC:   bus.exec_done  = rel;
         S_MEM:    bus.dmem_ready = rel;
         default:  ;
      endcase
      @(posedge clk);
      #1;
      if (es != S_IDLE && es != S_HALT) m_cyc = m_cyc + 32'd1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.start      = 1'($urandom);
      bus.imem_ready = 1'($urandom);
      bus.dmem_ready = 1'($urandom);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   // One instruction starting in FETCH: fw/ew/mw are wait cycles before the
   // respective ready/done arrives.
   task automatic run_insn(input int fw, input logic multi, input int ew,
                           input logic rd, input logic wr, input int mw,
                           input logic br, input logic [31:0] ba, input logic hlt);
      bus.exec_multi  = multi;
      bus.mem_read    = rd;
      bus.mem_write   = wr;
      bus.branch      = br;
      bus.branch_addr = ba;
      for (int i = 0; i < fw; i++) tick(S_FETCH, 1'b0);
      tick(S_FETCH, 1'b1);
      tick(S_DECODE, hlt);
      if (hlt) begin
         m_halted = 1'b1;
         return;
      end
      if (multi) begin
         for (int i = 0; i < ew; i++) tick(S_EXEC, 1'b0);
         tick(S_EXEC, 1'b1);
      end else begin
         tick(S_EXEC, 1'($urandom));
      end
      if (rd || wr) begin
         for (int i = 0; i < mw; i++) tick(S_MEM, 1'b0);
         tick(S_MEM, 1'b1);
      end else begin
         tick(S_MEM, 1'($urandom));
      end
      tick(S_WB, 1'($urandom));
      if (br && (ba[1:0] != 2'b00)) begin
         m_halted = 1'b1;
         m_fault  = 1'b1;
      end else begin
         m_pc  = br ? ba : (m_pc + 32'd4);
         m_ret = m_ret + 32'd1;
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.start = 1'b0;       bus.imem_ready = 1'b0; bus.halt_insn = 1'b0;
      bus.exec_multi = 1'b0;  bus.exec_done = 1'b0;  bus.mem_read = 1'b0;
      bus.mem_write = 1'b0;   bus.dmem_ready = 1'b0; bus.branch = 1'b0;
      bus.branch_addr = 32'd0;
      model_reset();

      do_reset();
      tick(S_IDLE, 1'b0);
      tick(S_IDLE, 1'b1);

      // Zero-wait straight-line code.
      repeat (3) run_insn(0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 32'd0, 1'b0);
      check_eq("line_pc",      bus.pc,          32'd12);
      check_eq("line_instret", bus.instret,     32'd3);
      check_eq("line_cycles",  bus.cycle_count, 32'd15);

      // Load, store, and read+write with data-memory wait states.
      run_insn(0, 1'b0, 0, 1'b1, 1'b0, 3, 1'b0, 32'd0, 1'b0);
      run_insn(0, 1'b0, 0, 1'b0, 1'b1, 3, 1'b0, 32'd0, 1'b0);
      run_insn(1, 1'b0, 0, 1'b1, 1'b1, 1, 1'b0, 32'd0, 1'b0);

      // Taken branch, FPU stall, and PC wrap at the top of the address space.
      run_insn(0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1, 32'h0000_0100, 1'b0);
      check_eq("branch_pc", bus.pc, 32'h0000_0100);
      run_insn(0, 1'b1, 3, 1'b0, 1'b0, 0, 1'b0, 32'd0, 1'b0);
      run_insn(0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1, 32'hFFFF_FFFC, 1'b0);
      run_insn(0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 32'd0, 1'b0);
      check_eq("wrap_pc", bus.pc, 32'h0000_0000);

      // Random aligned instruction mix.
      for (int n = 0; n < 40; n++) begin
         run_insn($urandom_range(0, 2), 1'($urandom), $urandom_range(0, 3),
                  1'($urandom), 1'($urandom), $urandom_range(0, 3),
                  ($urandom_range(0, 3) == 0), ($urandom & 32'hFFFF_FFFC), 1'b0);
      end

      // Misaligned branch target stops the core with pc and instret frozen.
      run_insn(0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1, 32'h0000_0100, 1'b0);
      run_insn(0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1, 32'h0000_0102, 1'b0);
      check_eq("misalign_pc",    bus.pc,          32'h0000_0100);
      check_eq("misalign_fault", 32'(bus.fault),  32'd1);
      repeat (3) tick(S_HALT, 1'b1);

      // Halt instruction; start afterwards is ignored.
      do_reset();
      tick(S_IDLE, 1'b1);
      run_insn(0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 32'd0, 1'b1);
      check_eq("halt_halted", 32'(bus.halted), 32'd1);
      repeat (3) tick(S_HALT, 1'b1);

      // Reset during the second MEM wait cycle abandons the access.
      do_reset();
      tick(S_IDLE, 1'b1);
      run_insn(0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 32'd0, 1'b0);
      bus.mem_read = 1'b1;
      bus.mem_write = 1'b0;
      tick(S_FETCH, 1'b1);
      tick(S_DECODE, 1'b0);
      tick(S_EXEC, 1'b1);
      tick(S_MEM, 1'b0);
      check_eq("mid_state",    32'(bus.state),    32'(S_MEM));
      check_eq("mid_dmem_req", 32'(bus.dmem_req), 32'd1);
      rst = 1'b1;
      bus.dmem_ready = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.dmem_ready = 1'b1;
      model_reset();
      check_eq("rst_state",    32'(bus.state),    32'(S_IDLE));
      check_eq("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
      check_eq("rst_pc",       bus.pc,            32'h0000_0000);
      bus.start = 1'b0;
      @(posedge clk);
      #1;
      tick(S_IDLE, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
Multi-cycle control sequencer for the scalar core.
- Generates the 3-bit `state` that gates the fetch, decode, exec and memory stages. The exec stage latches only while `state`==2.
- Owns the PC register.
- Runs the request/ready handshakes to instruction and data memory.
- Stalls EXEC for multi-cycle units (FPU).
- Stops the core on a halt instruction or a misaligned branch target.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, PC increment for non-branch instructions.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  level/pulse from loader; leaves IDLE
- imem_ready  in  1  instruction word valid this cycle
- imem_req  out  1  instruction fetch request
- halt_insn  in  1  decoder flags halt; valid in DECODE
- exec_multi  in  1  decoded op needs a multi-cycle unit; valid in EXEC
- exec_done  in  1  multi-cycle unit result ready
- mem_read  in  1  registered exec-stage output
- mem_write  in  1  registered exec-stage output
- dmem_ready  in  1  data access complete
- dmem_req  out  1  data memory request
- dmem_we  out  1  write strobe, qualifies dmem_req
- branch  in  1  registered exec-stage branch-taken flag
- branch_addr  in  32  registered exec-stage branch target
- state  out  3  IDLE=7, FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5
- pc  out  32  current instruction address
- halted  out  1  in HALT state
- fault  out  1  halt caused by misaligned branch target
- cycle_count  out  32  active cycles
- instret  out  32  retired instructions

Behaviour:
- Reset (synchronous, highest priority, wins over every other event):
  - state=IDLE, pc=RESET_PC, halted=0, fault=0, cycle_count=0, instret=0.
  - imem_req=0, dmem_req=0, dmem_we=0.
  - Reset asserted mid-handshake abandons the access. No request is asserted the cycle after reset.
- Strobe decoding:
  - imem_req = (state==FETCH).
  - dmem_req = (state==MEM) && (mem_read||mem_write).
  - dmem_we = dmem_req && mem_write. mem_write wins if mem_read is also set.
  - These are decoded from registered state, so they change only on clock edges.
- IDLE: start=1 → FETCH. Otherwise stay.
- FETCH:
  - Hold until imem_ready=1 sampled → DECODE.
  - With ready already high on entry, FETCH lasts exactly 1 cycle.
- DECODE: 1 cycle. halt_insn=1 → HALT; else → EXEC.
- EXEC: minimum 1 cycle.
  - exec_multi=0 → MEM.
  - exec_multi=1 → stay until exec_done=1, then → MEM.
  - exec_done sampled in the first EXEC cycle gives 1 cycle total.
  - The exec stage re-latches every EXEC cycle; its inputs are stable, so the results are unchanged.
- MEM:
  - No access → 1 cycle → WB.
  - Access → hold dmem_req until dmem_ready=1 sampled → WB.
- WB: 1 cycle.
  - branch=1 and branch_addr[1:0]!=0 → HALT, fault=1. pc and instret unchanged.
  - Otherwise → FETCH, with pc <= branch ? branch_addr : pc+PC_STEP (mod 2^32; wraps from 32'hFFFF_FFFC to 0), and instret += 1.
- HALT: terminal until rst. halted=1. start ignored.
- Ignored inputs:
  - start outside IDLE.
  - imem_ready outside FETCH.
  - dmem_ready outside MEM.
  - exec_done outside EXEC.
- Counters:
  - cycle_count += 1 every cycle state is not IDLE or HALT.
  - Both counters wrap at 2^32 silently.
- Latency: 5 cycles per instruction with zero-wait memory and single-cycle exec.

Decomposition:
- Shared package `core_pkg`:
  - State encoding constants (IDLE..HALT), which the exec stage also uses for its state==2 compare.
  - PC_STEP and RESET_PC defaults.
- Sub-module `perf_counters`: cycle_count and instret, with inc/active enables. All other logic stays inline as one FSM plus the PC register.

Test Plan:
- Reset values: rst high 2 cycles → state=7, pc=0, halted=0, fault=0, both counters 0, no requests. Then start=1 → state=0 next cycle, imem_req=1.
- Zero-wait straight line: imem_ready/dmem_ready tied 1, 3 non-memory instructions → state sequence 0,1,2,3,4 repeated; pc 0→4→8→12; instret=3; cycle_count=15.
- Load with wait states: mem_read=1, dmem_ready asserted on the 4th MEM cycle → dmem_req high exactly 4 cycles, dmem_we=0, WB follows. Store case: dmem_we=1 for the same window.
- Taken branch: branch=1, branch_addr=32'h100 at WB → pc=32'h100 in next FETCH. Misaligned target 32'h102 → state=5, fault=1, pc unchanged, instret unchanged.
- FPU stall and halt:
  - exec_multi=1, exec_done pulsed on the 4th EXEC cycle → 4 cycles in state 2, then 3.
  - halt_insn in DECODE → state=5, halted=1; start=1 afterwards has no effect.
- Reset mid-operation: rst asserted during the 2nd MEM wait cycle with dmem_req=1 → next cycle state=7, dmem_req=0, pc=RESET_PC. A late dmem_ready is ignored.
